// File: rtl/add5_operand_sequencer.sv
// Operand sequencer for an external 5-bit ripple adder (fulladder5).
// Optional decimal adjust at capture: define ADD5_BCD_CORRECT_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/valid/ready operand stream (A then B), 5 bits per beat
//   in_cin, in_chain    carry-in select, sampled with operand A
//   add_a4/add_a/add_b4/add_b/add_cin  operand pins driven to the adder
//   add_sum, add_carry  adder result pins
//   res_data/carry/ovf  captured result, res_valid/res_ready handshake
//   busy                high whenever not idle
module add5_operand_sequencer #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cin,
  input  logic       in_chain,
  output logic       add_a4,
  output logic [3:0] add_a,
  output logic       add_b4,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [4:0] add_sum,
  input  logic       add_carry,
  output logic [4:0] res_data,
  output logic       res_carry,
  output logic       res_ovf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    GET_B,
    EXEC,
    DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_last_carry;
  logic [4:0] r_a;
  logic [4:0] r_b;
  logic       r_cin;
  logic [4:0] r_res_data;
  logic       r_res_carry;
  logic       r_res_ovf;
  logic       r_res_valid;

  logic       w_ld_a;
  logic       w_ld_b;
  logic       w_cap;
  logic       w_ack;
  logic [4:0] w_cap_data;
  logic       w_cap_carry;
  logic       w_cap_ovf;

  always_comb begin
    w_next = r_state;
    w_ld_a = 1'b0;
    w_ld_b = 1'b0;
    w_cap  = 1'b0;
    w_ack  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_ld_a = 1'b1;
          w_next = GET_B;
        end
      end
      GET_B: begin
        if (in_valid) begin
          w_ld_b = 1'b1;
          w_next = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_cap  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_ack  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef ADD5_BCD_CORRECT_EN
  // Decimal adjust on the full 6-bit raw sum; digit >9 rolls by +6.
  logic [5:0] w_raw;
  logic       w_gt9;
  assign w_raw       = {add_carry, add_sum};
  assign w_gt9       = (w_raw > 6'd9);
  assign w_cap_data  = w_gt9 ? {1'b1, w_raw[3:0] + 4'd6}
                             : {1'b0, w_raw[3:0]};
  assign w_cap_carry = w_gt9;
  assign w_cap_ovf   = 1'b0;
`else
  assign w_cap_data  = add_sum;
  assign w_cap_carry = add_carry;
  // Signed overflow: like-signed operands, result sign differs.
  assign w_cap_ovf   = (r_a[4] == r_b[4]) &&
                       (add_sum[4] != r_a[4]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= 5'd0;
      r_b          <= 5'd0;
      r_cin        <= 1'b0;
      r_cnt        <= 4'd0;
      r_last_carry <= 1'b0;
      r_res_data   <= 5'd0;
      r_res_carry  <= 1'b0;
      r_res_ovf    <= 1'b0;
      r_res_valid  <= 1'b0;
    end else begin
      if (w_ld_a) begin
        r_a   <= in_data;
        r_cin <= in_chain ? r_last_carry : in_cin;
      end
      if (w_ld_b) begin
        r_b   <= in_data;
        r_cnt <= 4'(SETTLE_CYC - 1);
      end else if (r_state == EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_cap) begin
        r_res_data   <= w_cap_data;
        r_res_carry  <= w_cap_carry;
        r_res_ovf    <= w_cap_ovf;
        r_last_carry <= w_cap_carry;
        r_res_valid  <= 1'b1;
      end else if (w_ack) begin
        r_res_valid  <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE) || (r_state == GET_B);
  assign busy      = (r_state != IDLE);
  assign add_a4    = r_a[4];
  assign add_a     = r_a[3:0];
  assign add_b4    = r_b[4];
  assign add_b     = r_b[3:0];
  assign add_cin   = r_cin;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_ovf   = r_res_ovf;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_add5_operand_sequencer.sv
// Randomised bench for add5_operand_sequencer, two instances
// (settle 1 and 4) each wired to a behavioural 5-bit adder.
module tb_add5_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_data   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       in_cin    [2];
  logic       in_chain  [2];
  logic       add_a4    [2];
  logic [3:0] add_a     [2];
  logic       add_b4    [2];
  logic [3:0] add_b     [2];
  logic       add_cin   [2];
  logic [4:0] add_sum   [2];
  logic       add_carry [2];
  logic [4:0] res_data  [2];
  logic       res_carry [2];
  logic       res_ovf   [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic       busy      [2];

  int n_vec = 0;
  int n_err = 0;
  logic model_lc [2];
  logic [4:0] g_data;
  logic       g_carry;
  logic       g_ovf;
  logic       g_cin;

  always #5 clk = ~clk;

  add5_operand_sequencer #(.SETTLE_CYC(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_cin(in_cin[0]),
    .in_chain(in_chain[0]),
    .add_a4(add_a4[0]), .add_a(add_a[0]),
    .add_b4(add_b4[0]), .add_b(add_b[0]),
    .add_cin(add_cin[0]), .add_sum(add_sum[0]),
    .add_carry(add_carry[0]),
    .res_data(res_data[0]), .res_carry(res_carry[0]),
    .res_ovf(res_ovf[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .busy(busy[0])
  );

  add5_operand_sequencer #(.SETTLE_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_cin(in_cin[1]),
    .in_chain(in_chain[1]),
    .add_a4(add_a4[1]), .add_a(add_a[1]),
    .add_b4(add_b4[1]), .add_b(add_b[1]),
    .add_cin(add_cin[1]), .add_sum(add_sum[1]),
    .add_carry(add_carry[1]),
    .res_data(res_data[1]), .res_carry(res_carry[1]),
    .res_ovf(res_ovf[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .busy(busy[1])
  );

  // Behavioural stand-in for fulladder5.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      {add_carry[d], add_sum[d]} =
        6'({add_a4[d], add_a[d]}) +
        6'({add_b4[d], add_b[d]}) +
        6'(add_cin[d]);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int settle(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // One full transaction: A, B, result wait, hold, handshake.
  task automatic txn(input int d, input logic [4:0] a,
                     input logic [4:0] b, input logic cin,
                     input logic chain, input int hold);
    int k;
    int sa, sb, s, raw;
    logic cexp;
    logic stable;
    logic [4:0] ed;
    logic ec, eo;
    cexp = chain ? model_lc[d] : cin;
    @(negedge clk);
    in_data[d]  = a;
    in_cin[d]   = cin;
    in_chain[d] = chain;
    in_valid[d] = 1'b1;
    k = 0;
    while (!in_ready[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("a_ready", in_ready[d], 1);
    @(negedge clk);
    in_data[d]  = b;
    in_cin[d]   = 1'($urandom);
    in_chain[d] = 1'($urandom);
    check("a_reg", {add_a4[d], add_a[d]}, a);
    check("cin_sel", add_cin[d], cexp);
    check("b_ready", in_ready[d], 1);
    @(negedge clk);
    in_data[d] = 5'($urandom);
    k = 1;
    stable = 1'b1;
    while (!res_valid[d] && k < 40) begin
      if ({add_a4[d], add_a[d]} != a ||
          {add_b4[d], add_b[d]} != b ||
          add_cin[d] != cexp || in_ready[d] || !busy[d])
        stable = 1'b0;
      @(negedge clk);
      k++;
    end
    check("latency", k, settle(d) + 1);
    check("exec_hold", stable, 1);
    raw = int'(a) + int'(b) + int'(cexp);
`ifdef ADD5_BCD_CORRECT_EN
    ec = (raw > 9);
    ed = ec ? (5'd16 | 5'((raw + 6) % 16)) : 5'(raw % 16);
    eo = 1'b0;
`else
    sa = a[4] ? int'(a) - 32 : int'(a);
    sb = b[4] ? int'(b) - 32 : int'(b);
    s  = sa + sb + int'(cexp);
    ed = 5'(raw % 32);
    ec = (raw >= 32);
    eo = (s > 15) || (s < -16);
`endif
    check("res_data", res_data[d], ed);
    check("res_carry", res_carry[d], ec);
    check("res_ovf", res_ovf[d], eo);
    model_lc[d] = ec;
    g_data  = res_data[d];
    g_carry = res_carry[d];
    g_ovf   = res_ovf[d];
    g_cin   = add_cin[d];
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!res_valid[d] || in_ready[d] || res_data[d] != ed ||
          {add_a4[d], add_a[d]} != a)
        stable = 1'b0;
    end
    check("backpressure", stable, 1);
    res_ready[d] = 1'b1;
    in_valid[d]  = 1'b0;
    @(negedge clk);
    res_ready[d] = 1'b0;
    check("ack_valid", res_valid[d], 0);
    check("ack_busy", busy[d], 0);
    check("ack_ready", in_ready[d], 1);
  endtask

  task automatic abort_test();
    int k;
    @(negedge clk);
    in_data[1]  = 5'h0f;
    in_cin[1]   = 1'b0;
    in_chain[1] = 1'b1;
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_data[1] = 5'h0f;
    @(negedge clk);
    in_valid[1] = 1'b0;
    check("abort_busy_pre", busy[1], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_lc[0] = 1'b0;
    model_lc[1] = 1'b0;
    check("abort_busy", busy[1], 0);
    check("abort_ready", in_ready[1], 1);
    check("abort_cin", add_cin[1], 0);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid[1]) k++;
    end
    check("abort_novalid", k, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_data[d]   = 5'd0;
      in_valid[d]  = 1'b0;
      in_cin[d]    = 1'b0;
      in_chain[d]  = 1'b0;
      res_ready[d] = 1'b0;
      model_lc[d]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", in_ready[d], 1);
      check("rst_busy", busy[d], 0);
      check("rst_valid", res_valid[d], 0);
      check("rst_add", {add_a4[d], add_a[d], add_b4[d],
                        add_b[d], add_cin[d]}, 0);
      check("rst_res", {res_data[d], res_carry[d],
                        res_ovf[d]}, 0);
    end

    txn(0, 5'b01001, 5'b01001, 1'b0, 1'b0, 0);
`ifdef ADD5_BCD_CORRECT_EN
    check("bcd_9p9", {g_data, g_carry}, {5'b11000, 1'b1});
    txn(0, 5'b00100, 5'b00101, 1'b0, 1'b0, 0);
    check("bcd_4p5", {g_data, g_carry}, {5'b01001, 1'b0});
`else
    check("basic", {g_data, g_carry, g_ovf},
          {5'b10010, 1'b0, 1'b1});
`endif
    txn(0, 5'b11111, 5'b00001, 1'b0, 1'b0, 5);
`ifndef ADD5_BCD_CORRECT_EN
    check("wrap", {g_data, g_carry, g_ovf},
          {5'b00000, 1'b1, 1'b0});
`endif
    txn(0, 5'b00000, 5'b00000, 1'b0, 1'b1, 0);
    check("chain", {g_cin, g_data}, {1'b1, 5'b00001});

    txn(1, 5'b11111, 5'b00001, 1'b0, 1'b0, 2);
    abort_test();
    txn(1, 5'b00000, 5'b00000, 1'b1, 1'b1, 0);
    check("post_abort", {g_cin, g_data}, 6'd0);

    for (int n = 0; n < 40; n++) begin
      txn(n % 2, 5'($urandom), 5'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
